// File: rtl/tenkey_drv.sv
// Ten-key press driver: queues BCD digits and replays each as a timed one-hot key strobe.
// Latency: a digit reaches tenkey one edge after acceptance when idle; backpressure via in_ready (4-deep queue).

module tenkey_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               wdat,
    input  logic                       pop,
    output logic [W-1:0]               rdat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdat    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdat;
        end
    end

    // Power-of-two depth, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module tenkey_drv #(
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_digit,
    output logic       in_ready,
    output logic [9:0] tenkey,
    output logic       busy,
    output logic       err
);
    localparam logic [7:0] PRESS_LOAD = 8'(PRESS_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] fifo_count;
    logic [3:0] head;
    logic       fifo_empty;
    logic       accept;
    logic       code_ok;
    logic       push;
    logic       bad_code;
    logic       pop;
    logic       cnt_done;

    function automatic logic [9:0] one_hot(input logic [3:0] d);
        logic [9:0] v;
        v = 10'd1 << d;
        return v;
    endfunction

    assign fifo_empty = (fifo_count == 3'd0);
    // A full queue refuses input even when the head is popped on the same edge.
    assign in_ready   = (fifo_count < 3'd4);
    assign busy       = (state != IDLE) | ~fifo_empty;
    assign accept     = in_valid & in_ready;
    assign code_ok    = (in_digit <= 4'd9);
    assign push       = accept & code_ok;
    assign bad_code   = accept & ~code_ok;
    assign cnt_done   = (cnt == 8'd0);
    assign pop        = ~fifo_empty & ((state == IDLE) | ((state == GAP) & cnt_done));

    tenkey_fifo #(
        .W     (4),
        .DEPTH (4)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdat  (in_digit),
        .pop   (pop),
        .rdat  (head),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            tenkey <= '0;
            cnt    <= 8'd0;
            err    <= 1'b0;
        end else begin
            err <= bad_code;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state  <= PRESS;
                        tenkey <= one_hot(head);
                        cnt    <= PRESS_LOAD;
                    end
                end
                PRESS: begin
                    if (cnt_done) begin
                        state  <= GAP;
                        tenkey <= '0;
                        cnt    <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (!cnt_done) begin
                        cnt <= cnt - 8'd1;
                    end else if (pop) begin
                        state  <= PRESS;
                        tenkey <= one_hot(head);
                        cnt    <= PRESS_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tenkey <= '0;
                    cnt    <= 8'd0;
                end
            endcase
        end
    end
endmodule
